// File: rtl/tl_mem_responder.sv
// ---------------------------------------------------------------------------
// tl_mem_responder
//   Active TileLink-UL slave endpoint backed by a word-addressed memory model.
//   Accepts Get / PutFullData / PutPartialData on channel A and answers on
//   channel D. It handles one transaction at a time and supports multi-beat
//   requests. Response latency is programmable through LATENCY.
//
//   Optional build macro: TL_MEM_RESPONDER_DENY_EN
//     When defined, a request is refused if any a_address bit above the
//     memory range is nonzero. A Put is not written. A Get returns corrupt,
//     denied, zero data. When undefined, the upper bits are ignored and
//     addresses alias modulo the memory size.
//
//   Ports
//     clock, reset_n       rising-edge clock, async active-low reset
//     a_*                  channel A request (valid/ready, opcode, size,
//                          source, address, mask, data, corrupt; param unused)
//     d_*                  channel D response (valid/ready, opcode, param,
//                          size, source, sink, denied, data, corrupt)
//     err_sticky           set by any unsupported opcode, cleared by reset
//     dbg_state            current FSM state (IDLE=0, PUT=1, WAIT=2, RESP=3)
//
//   Handshake: a beat transfers on a rising edge where valid && ready.
//   A valid source holds every payload field stable until that edge.
//   ready may depend on state but never on the partner's valid.
// ---------------------------------------------------------------------------
module tl_mem_responder #(
    parameter int          ADDR_WD    = 36,
    parameter int          DATA_WD    = 256,
    parameter int          SIZE_WD    = 3,
    parameter int          SOURCE_WD  = 32,
    parameter int          SINK_WD    = 32,
    parameter int          DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [2:0]             a_param,
    input  logic [SIZE_WD-1:0]     a_size,
    input  logic [SOURCE_WD-1:0]   a_source,
    input  logic [ADDR_WD-1:0]     a_address,
    input  logic [DATA_WD/8-1:0]   a_mask,
    input  logic [DATA_WD-1:0]     a_data,
    input  logic                   a_corrupt,
    output logic                   d_valid,
    input  logic                   d_ready,
    output logic [2:0]             d_opcode,
    output logic [1:0]             d_param,
    output logic [SIZE_WD-1:0]     d_size,
    output logic [SOURCE_WD-1:0]   d_source,
    output logic [SINK_WD-1:0]     d_sink,
    output logic                   d_denied,
    output logic [DATA_WD-1:0]     d_data,
    output logic                   d_corrupt,
    output logic                   err_sticky,
    output logic [1:0]             dbg_state
);

    localparam int BEAT_BYTES = DATA_WD / 8;
    localparam int OFF        = $clog2(BEAT_BYTES);
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    // Wide enough to hold the beat count of the largest encodable request.
    localparam int CNT_WD     = 1 << SIZE_WD;
    localparam logic [31:0] LAT_LAST = (LATENCY == 0) ? 32'd0 : 32'(LATENCY - 1);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUT  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                  r_state, w_next;
    logic [2:0]              r_opcode;
    logic [SIZE_WD-1:0]      r_size;
    logic [SOURCE_WD-1:0]    r_source;
    logic [DEPTH_LOG2-1:0]   r_base;
    logic [CNT_WD-1:0]       r_total;
    logic [CNT_WD-1:0]       r_beat;
    logic [31:0]             r_lat_cnt;
    logic                    r_denied;
    logic                    r_oob;
    logic                    r_err;

    logic [DATA_WD-1:0]      r_mem [DEPTH];

    logic                    w_a_fire, w_d_fire;
    logic                    w_a_is_put, w_a_is_get, w_a_bad;
    logic                    w_r_is_put, w_r_is_get;
    logic [CNT_WD-1:0]       w_a_beats;
    logic [CNT_WD-1:0]       w_resp_beats;
    logic [DEPTH_LOG2-1:0]   w_a_base;
    logic [DEPTH_LOG2-1:0]   w_beat_idx;
    logic                    w_a_oob;
    logic                    w_put_last, w_resp_last;
    logic                    w_resp;
    logic                    w_we;
    logic [DEPTH_LOG2-1:0]   w_widx;
    logic                    w_unused;

    assign w_a_is_put = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
    assign w_a_is_get = (a_opcode == OP_GET);
    assign w_a_bad    = !(w_a_is_put || w_a_is_get);
    assign w_r_is_put = (r_opcode == OP_PUT_FULL) || (r_opcode == OP_PUT_PART);
    assign w_r_is_get = (r_opcode == OP_GET);

    assign w_a_base   = a_address[OFF+DEPTH_LOG2-1:OFF];
    // Beat k of the latched request; the index wraps modulo the memory depth.
    assign w_beat_idx = r_base + DEPTH_LOG2'(r_beat);

`ifdef TL_MEM_RESPONDER_DENY_EN
    assign w_a_oob  = |a_address[ADDR_WD-1:OFF+DEPTH_LOG2];
    assign w_unused = &{1'b0, a_param, a_address[OFF-1:0]};
`else
    assign w_a_oob  = 1'b0;
    assign w_unused = &{1'b0, a_param, a_address[ADDR_WD-1:OFF+DEPTH_LOG2],
                        a_address[OFF-1:0]};
`endif

    always_comb begin
        w_a_beats = CNT_WD'(1);
        if (int'(a_size) > OFF) begin
            w_a_beats = CNT_WD'(1) << (int'(a_size) - OFF);
        end
    end

    // Reset gates ready combinationally, so no beat is taken while reset is low.
    assign a_ready  = reset_n && ((r_state == S_IDLE) || (r_state == S_PUT));
    assign w_a_fire = a_valid && a_ready;
    assign w_d_fire = d_valid && d_ready;

    assign w_resp_beats = w_r_is_get ? r_total : CNT_WD'(1);
    assign w_put_last   = (r_beat == r_total - CNT_WD'(1));
    assign w_resp_last  = (r_beat == w_resp_beats - CNT_WD'(1));

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_a_fire) begin
                    if (!w_a_is_get && (w_a_beats > CNT_WD'(1))) begin
                        w_next = S_PUT;
                    end else begin
                        w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
                    end
                end
            end
            S_PUT: begin
                if (w_a_fire && w_put_last) begin
                    w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_d_fire && w_resp_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Write decision. Corrupt beats, refused requests and unsupported
    // opcodes never reach memory.
    always_comb begin
        w_we   = 1'b0;
        w_widx = w_a_base;
        if (w_a_fire) begin
            if (r_state == S_IDLE) begin
                w_we   = w_a_is_put && !a_corrupt && !w_a_oob;
                w_widx = w_a_base;
            end else begin
                w_we   = w_r_is_put && !a_corrupt && !r_oob;
                w_widx = w_beat_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
                if (a_mask[b]) begin
                    r_mem[w_widx][b*8 +: 8] <= a_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_opcode  <= 3'd0;
            r_size    <= '0;
            r_source  <= '0;
            r_base    <= '0;
            r_total   <= '0;
            r_beat    <= '0;
            r_lat_cnt <= '0;
            r_denied  <= 1'b0;
            r_oob     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_a_fire) begin
                        r_opcode  <= a_opcode;
                        r_size    <= a_size;
                        r_source  <= a_source;
                        r_base    <= w_a_base;
                        r_total   <= w_a_beats;
                        r_oob     <= w_a_oob;
                        r_lat_cnt <= '0;
                        r_beat    <= (w_next == S_PUT) ? CNT_WD'(1) : '0;
                        r_denied  <= (w_a_is_put && a_corrupt) || w_a_bad || w_a_oob;
                        if (w_a_bad) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_PUT: begin
                    if (w_a_fire) begin
                        if (w_r_is_put && a_corrupt) begin
                            r_denied <= 1'b1;
                        end
                        r_beat <= w_put_last ? '0 : r_beat + CNT_WD'(1);
                    end
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 32'd1;
                end
                S_RESP: begin
                    if (w_d_fire) begin
                        r_beat <= w_resp_last ? '0 : r_beat + CNT_WD'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // D fields are pure functions of held state, so they cannot change
    // while a beat is stalled. They read as zero outside RESP.
    assign w_resp     = (r_state == S_RESP);
    assign d_valid    = w_resp;
    assign d_opcode   = (w_resp && w_r_is_get) ? 3'd1 : 3'd0;
    assign d_param    = 2'd0;
    assign d_sink     = '0;
    assign d_size     = w_resp ? r_size : '0;
    assign d_source   = w_resp ? r_source : '0;
    assign d_denied   = w_resp && r_denied;
    assign d_corrupt  = w_resp && w_r_is_get && r_oob;
    assign d_data     = (w_resp && w_r_is_get && !r_oob) ? r_mem[w_beat_idx] : '0;
    assign err_sticky = r_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_tl_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_tl_mem_responder
//   Randomized bench for tl_mem_responder. A behavioural memory model
//   predicts every channel D beat from the TileLink rules. The bench also
//   runs directed cases for latency, stalls, partial writes, unsupported
//   opcodes, index wrap and reset during a response.
// ---------------------------------------------------------------------------
module tb_tl_mem_responder;

    localparam int ADDR_WD    = 36;
    localparam int DATA_WD    = 256;
    localparam int SIZE_WD    = 3;
    localparam int SOURCE_WD  = 32;
    localparam int SINK_WD    = 32;
    localparam int DEPTH_LOG2 = 8;
    localparam int LATENCY    = 2;
    localparam int DEPTH      = 256;
    localparam int D_W        = 2 + 32 + 3 + 3 + 32 + 1 + 1 + 256;

    logic                   clock;
    logic                   reset_n;
    logic                   a_valid;
    logic                   a_ready;
    logic [2:0]             a_opcode;
    logic [2:0]             a_param;
    logic [SIZE_WD-1:0]     a_size;
    logic [SOURCE_WD-1:0]   a_source;
    logic [ADDR_WD-1:0]     a_address;
    logic [DATA_WD/8-1:0]   a_mask;
    logic [DATA_WD-1:0]     a_data;
    logic                   a_corrupt;
    logic                   d_valid;
    logic                   d_ready;
    logic [2:0]             d_opcode;
    logic [1:0]             d_param;
    logic [SIZE_WD-1:0]     d_size;
    logic [SOURCE_WD-1:0]   d_source;
    logic [SINK_WD-1:0]     d_sink;
    logic                   d_denied;
    logic [DATA_WD-1:0]     d_data;
    logic                   d_corrupt;
    logic                   err_sticky;
    logic [1:0]             dbg_state;

    tl_mem_responder #(
        .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .SIZE_WD(SIZE_WD),
        .SOURCE_WD(SOURCE_WD), .SINK_WD(SINK_WD), .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY(LATENCY)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data),
        .d_corrupt(d_corrupt), .err_sticky(err_sticky), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- model and scoreboard ----------------
    logic [DATA_WD-1:0] ref_mem [DEPTH];
    logic               ref_err;
    logic [D_W-1:0]     exp_q[$];
    int                 n_checks;
    int                 n_fail;

    logic [DATA_WD-1:0] tx_data    [4];
    logic [31:0]        tx_mask    [4];
    logic               tx_corrupt [4];

    task automatic check_eq(input string tag, input logic [D_W-1:0] obs,
                            input logic [D_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D_W-1:0] pack_d(input logic [2:0] op, input logic [2:0] sz,
                                              input logic [31:0] src, input logic den,
                                              input logic cor, input logic [255:0] dat);
        return {2'b00, 32'd0, op, sz, src, den, cor, dat};
    endfunction

    function automatic logic [D_W-1:0] obs_d();
        return {d_param, d_sink, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
    endfunction

    function automatic logic [255:0] rand_data();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] fill_byte(input logic [7:0] b);
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    function automatic int beats_of(input logic [2:0] sz);
        return (int'(sz) > 5) ? (1 << (int'(sz) - 5)) : 1;
    endfunction

    // ---------------- driver ----------------
    // stall_mode 1 holds d_ready low for four cycles on the first D beat.
    task automatic run_txn(input logic [2:0] op, input logic [2:0] sz,
                           input logic [31:0] src, input logic [35:0] addr,
                           input int stall_mode);
        int   n, na, base, idx, lat, stalls, guard;
        logic oob, den, is_put, is_get;
        n      = beats_of(sz);
        base   = int'(addr[12:5]);
        is_put = (op == 3'd0) || (op == 3'd1);
        is_get = (op == 3'd4);
        na     = is_get ? 1 : n;
`ifdef TL_MEM_RESPONDER_DENY_EN
        oob = (addr[35:13] != 0);
`else
        oob = 1'b0;
`endif
        // Predict the response and update the memory model.
        if (is_get) begin
            for (int k = 0; k < n; k++) begin
                idx = (base + k) % DEPTH;
                exp_q.push_back(pack_d(3'd1, sz, src, oob, oob, oob ? '0 : ref_mem[idx]));
            end
        end else begin
            den = oob || !is_put;
            if (!is_put) ref_err = 1'b1;
            if (is_put) begin
                for (int k = 0; k < n; k++) begin
                    idx = (base + k) % DEPTH;
                    if (tx_corrupt[k]) den = 1'b1;
                    else if (!oob) begin
                        for (int b = 0; b < 32; b++)
                            if (tx_mask[k][b]) ref_mem[idx][b*8 +: 8] = tx_data[k][b*8 +: 8];
                    end
                end
            end
            exp_q.push_back(pack_d(3'd0, sz, src, den, 1'b0, '0));
        end

        // Channel A beats; follow-on beats carry junk header fields.
        for (int k = 0; k < na; k++) begin
            @(negedge clock);
            if (k > 0 && $urandom_range(0, 2) == 0) begin
                a_valid = 1'b0;
                @(negedge clock);
            end
            a_valid   = 1'b1;
            a_opcode  = (k == 0) ? op  : 3'($urandom_range(0, 7));
            a_size    = (k == 0) ? sz  : 3'($urandom_range(0, 7));
            a_source  = (k == 0) ? src : $urandom;
            a_param   = 3'($urandom_range(0, 7));
            a_address = addr + 36'(k * 32);
            a_mask    = tx_mask[k];
            a_data    = tx_data[k];
            a_corrupt = tx_corrupt[k];
            guard = 0;
            while (!a_ready && guard < 20) begin
                @(negedge clock);
                guard++;
            end
            if (!a_ready) begin
                check_eq("a_ready_timeout", D_W'(0), D_W'(1));
                a_valid = 1'b0;
                exp_q.delete();
                return;
            end
            @(posedge clock);
        end
        @(negedge clock);
        a_valid   = 1'b0;
        a_corrupt = 1'b0;

        // Latency: first D beat is LATENCY+1 cycles after the last A fire.
        lat = 1;
        while (!d_valid && lat <= 20) begin
            check_eq("a_ready_in_wait", D_W'(a_ready), D_W'(0));
            @(negedge clock);
            lat++;
        end
        check_eq("latency", D_W'(lat), D_W'(LATENCY + 1));

        // Channel D beats, compared on every sampled cycle including stalls.
        stalls = 0;
        guard  = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            guard++;
            check_eq("d_valid", D_W'(d_valid), D_W'(1));
            if (!d_valid) break;
            check_eq("d_beat", obs_d(), exp_q[0]);
            if (stall_mode == 1 && exp_q.size() == n && stalls < 4) begin
                d_ready = 1'b0;
                stalls++;
            end else begin
                d_ready = ($urandom_range(0, 3) != 0);
            end
            if (d_ready) begin
                @(posedge clock);
                void'(exp_q.pop_front());
            end
            @(negedge clock);
        end
        if (exp_q.size() != 0) begin
            check_eq("d_beats_missing", D_W'(exp_q.size()), D_W'(0));
            exp_q.delete();
        end
        d_ready = 1'b0;
        check_eq("d_valid_after", D_W'(d_valid), D_W'(0));
        check_eq("a_ready_idle", D_W'(a_ready), D_W'(1));
        check_eq("err_sticky", D_W'(err_sticky), D_W'(ref_err));
    endtask

    task automatic set_beats(input logic [255:0] dat, input logic [31:0] msk);
        for (int k = 0; k < 4; k++) begin
            tx_data[k]    = dat;
            tx_mask[k]    = msk;
            tx_corrupt[k] = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [35:0] addr;
        logic [2:0]  op;
        int          r, guard;
        n_checks = 0;
        n_fail   = 0;
        ref_err  = 1'b0;
        reset_n  = 1'b0;
        a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0; d_ready = 1'b0;
        set_beats('0, '1);

        repeat (2) @(negedge clock);
        check_eq("rst_a_ready", D_W'(a_ready), D_W'(0));
        check_eq("rst_d_valid", D_W'(d_valid), D_W'(0));
        check_eq("rst_err", D_W'(err_sticky), D_W'(0));
        check_eq("rst_d_fields", obs_d(), D_W'(0));
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("post_rst_a_ready", D_W'(a_ready), D_W'(1));

        // Give every line a known value.
        for (int i = 0; i < DEPTH; i++) begin
            set_beats(rand_data(), '1);
            run_txn(3'd0, 3'd5, 32'(i), 36'(i * 32), 0);
        end

        // PutFullData A5 at 0x40, then read it back.
        set_beats(fill_byte(8'hA5), '1);
        run_txn(3'd0, 3'd5, 32'h1234_5678, 36'h40, 0);
        run_txn(3'd4, 3'd5, 32'h0000_0077, 36'h40, 0);

        // Two-beat Get with stall on beat 0.
        set_beats(fill_byte(8'hD0), '1);
        run_txn(3'd0, 3'd5, 32'd1, 36'h80, 0);
        set_beats(fill_byte(8'hD1), '1);
        run_txn(3'd0, 3'd5, 32'd2, 36'hA0, 0);
        run_txn(3'd4, 3'd6, 32'hCAFE_F00D, 36'h80, 1);

        // Partial write onto a zero line.
        set_beats('0, '1);
        run_txn(3'd0, 3'd5, 32'd3, 36'hC0, 0);
        set_beats(fill_byte(8'hFF), 32'h0000_000F);
        run_txn(3'd1, 3'd5, 32'd4, 36'hC0, 0);
        check_eq("partial_model", D_W'(ref_mem[6]), D_W'(256'hFFFF_FFFF));
        run_txn(3'd4, 3'd5, 32'd5, 36'hC0, 0);

        // Corrupt beat in a two-beat Put: beat 1 dropped, ack denied.
        set_beats(fill_byte(8'h3C), '1);
        tx_corrupt[1] = 1'b1;
        run_txn(3'd0, 3'd6, 32'd6, 36'h100, 0);
        run_txn(3'd4, 3'd6, 32'd7, 36'h100, 0);

        // Unsupported opcode: denied ack, sticky error.
        set_beats(rand_data(), '1);
        run_txn(3'd6, 3'd5, 32'hBAD0_0006, 36'h40, 0);
        check_eq("err_set", D_W'(err_sticky), D_W'(1));
        run_txn(3'd3, 3'd7, 32'hBAD0_0003, 36'h200, 0);

        // Two-beat Put at the last index wraps to index 0.
        tx_data[0] = fill_byte(8'h11);
        tx_data[1] = fill_byte(8'h22);
        run_txn(3'd0, 3'd6, 32'd8, 36'h1FE0, 0);
        run_txn(3'd4, 3'd5, 32'd9, 36'h0, 0);
        run_txn(3'd4, 3'd6, 32'd10, 36'h1FE0, 0);

`ifdef TL_MEM_RESPONDER_DENY_EN
        set_beats(fill_byte(8'h99), '1);
        run_txn(3'd0, 3'd5, 32'd11, 36'h8_0000_0040, 0);
        run_txn(3'd4, 3'd6, 32'd12, 36'h8_0000_0040, 0);
        run_txn(3'd4, 3'd5, 32'd13, 36'h40, 0);
`endif

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      op = 3'd0;
            else if (r < 5) op = 3'd1;
            else if (r < 9) op = 3'd4;
            else begin
                case ($urandom_range(0, 4))
                    0: op = 3'd2;
                    1: op = 3'd3;
                    2: op = 3'd5;
                    3: op = 3'd6;
                    default: op = 3'd7;
                endcase
            end
            addr = {4'($urandom), 32'($urandom)};
`ifdef TL_MEM_RESPONDER_DENY_EN
            if ($urandom_range(0, 7) != 0) addr[35:13] = '0;
`endif
            for (int k = 0; k < 4; k++) begin
                tx_data[k]    = rand_data();
                tx_mask[k]    = (op == 3'd1) ? $urandom : 32'hFFFF_FFFF;
                tx_corrupt[k] = ($urandom_range(0, 9) == 0);
            end
            run_txn(op, 3'($urandom_range(0, 7)), $urandom, addr, $urandom_range(0, 1));
        end

        // Reset during RESP of a two-beat Get.
        @(negedge clock);
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd6; a_source = 32'd99;
        a_address = 36'h80; a_corrupt = 1'b0;
        guard = 0;
        while (!a_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        @(negedge clock);
        a_valid = 1'b0;
        guard = 0;
        while (!d_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check_eq("rst_test_d_valid", D_W'(d_valid), D_W'(1));
        reset_n = 1'b0;
        #1;
        ref_err = 1'b0;
        check_eq("mid_rst_d_valid", D_W'(d_valid), D_W'(0));
        check_eq("mid_rst_a_ready", D_W'(a_ready), D_W'(0));
        check_eq("mid_rst_d_fields", obs_d(), D_W'(0));
        check_eq("mid_rst_err", D_W'(err_sticky), D_W'(0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        d_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("post_rst_no_beat", D_W'(d_valid), D_W'(0));
            check_eq("post_rst_ready", D_W'(a_ready), D_W'(1));
        end
        d_ready = 1'b0;

        // Memory survives reset.
        run_txn(3'd4, 3'd6, 32'd100, 36'h80, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
